// File: rtl/fetch_pair_queue_if.sv
// Instruction memory bus between the fetch queue (master) and instruction memory (slave).
// Single outstanding request, no ready: memory always accepts a request in its issue cycle.
interface fetch_pair_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pair_queue.sv
// Sequential instruction fetch into a circular queue; presents the two oldest words
// as a pair to the dual-issue scheduler and accepts a branch redirect (flush).
module fetch_pair_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      n_rst,
    fetch_pair_queue_if.master        imem,
    input  logic                      flush,
    input  logic [31:0]               flush_pc,
    input  logic                      freeze1,
    input  logic                      freeze2,
    output logic [31:0]               instruction0,
    output logic [31:0]               instruction1,
    output logic                      nothing_filled
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned PW       = AW + 1;
    localparam logic [PW-1:0] FULL     = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);

    typedef enum logic [1:0] {StBoot, StIdle, StWait, StDiscard} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_q [DEPTH];

    logic          req;
    logic          push;
    logic [1:0]    pop_cnt;
    logic [AW-1:0] rd_idx0;
    logic [AW-1:0] rd_idx1;

    // Fetch FSM: next state, request, pc advance and push decision.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        push    = 1'b0;
        case (state_q)
            StBoot: state_d = StIdle;
            StIdle: begin
                if (!flush && (count_q < FULL)) begin
                    req     = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A flush drops the in-flight word; if it has not arrived yet it must be
                // swallowed later in StDiscard so it never lands after the redirect.
                if (flush) begin
                    state_d = imem.imem_rvalid ? StIdle : StDiscard;
                end else if (imem.imem_rvalid) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            StDiscard: begin
                if (imem.imem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StBoot;
        endcase
        if (flush) begin
            pc_d = flush_pc;
        end
    end

    // Pop up to two entries when the scheduler is not frozen.
    always_comb begin
        pop_cnt = 2'd0;
        if (!freeze1 && !freeze2 && !flush) begin
            pop_cnt = (count_q >= PW'(2)) ? 2'd2 : count_q[1:0];
        end
    end

    // Queue bookkeeping; flush empties the queue and overrides push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = (rd_ptr_q + PW'(pop_cnt)) & PTR_MASK;
            if (push) begin
                wr_ptr_d = (wr_ptr_q + PW'(1)) & PTR_MASK;
            end
            count_d = count_q + PW'(push) - PW'(pop_cnt);
        end
    end

    // State, pc and pointer registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StBoot;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Queue storage; contents are only observed through count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= imem.imem_rdata;
        end
    end

    assign rd_idx0 = rd_ptr_q[AW-1:0];
    assign rd_idx1 = rd_ptr_q[AW-1:0] + AW'(1);

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    assign instruction0   = (count_q >= PW'(1)) ? mem_q[rd_idx0] : 32'h0;
    assign instruction1   = (count_q >= PW'(2)) ? mem_q[rd_idx1] : 32'h0;
    assign nothing_filled = (count_q == '0);

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Self-checking bench for fetch_pair_queue: scenario tasks plus a randomized run, all
// checked against a queue-based reference model of fetch/pop/flush behaviour.
module tb_fetch_pair_queue;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        freeze1;
    logic        freeze2;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        nothing_filled;

    fetch_pair_queue_if imem ();

    fetch_pair_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .imem           (imem),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .freeze1        (freeze1),
        .freeze2        (freeze2),
        .instruction0   (instruction0),
        .instruction1   (instruction1),
        .nothing_filled (nothing_filled)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Cycle counter used to schedule memory responses.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: word = addr + 0x100, latency drawn from [lat_min, lat_max].
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } resp_t;
    resp_t       pend[$];
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    always @(negedge clk) begin
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            imem.imem_rvalid = 1'b0;
            imem.imem_rdata  = $urandom;
        end
        #1;
        if (imem.imem_req === 1'b1) begin
            pend.push_back('{due: cyc + $urandom_range(lat_max, lat_min),
                             data: imem.imem_addr + 32'h100});
        end
    end

    // Reference model: queued words, next fetch address, request/stale bookkeeping.
    logic [31:0] mq[$];
    logic [31:0] m_pc;
    bit          m_booted;
    bit          m_in_flight;
    bit          m_stale;

    logic        obs_req, obs_nf, obs_rv;
    logic [31:0] obs_addr, obs_i0, obs_i1;
    logic        exp_req, exp_nf;
    logic [31:0] exp_addr, exp_i0, exp_i1;

    task automatic model_reset();
        mq.delete();
        m_pc        = RESET_PC;
        m_booted    = 1'b0;
        m_in_flight = 1'b0;
        m_stale     = 1'b0;
    endtask

    // One clock cycle: sample DUT and model expectations mid-cycle, then advance the model.
    task automatic cycle();
        int npop;
        logic [31:0] rd;
        @(negedge clk);
        #1;
        obs_req  = imem.imem_req;
        obs_addr = imem.imem_addr;
        obs_i0   = instruction0;
        obs_i1   = instruction1;
        obs_nf   = nothing_filled;
        obs_rv   = imem.imem_rvalid;
        rd       = imem.imem_rdata;
        exp_req  = m_booted && !m_in_flight && !m_stale && (mq.size() < DEPTH) && !flush;
        exp_addr = m_pc;
        exp_i0   = (mq.size() >= 1) ? mq[0] : 32'h0;
        exp_i1   = (mq.size() >= 2) ? mq[1] : 32'h0;
        exp_nf   = (mq.size() == 0);
        if (flush) begin
            mq.delete();
            m_pc     = flush_pc;
            m_booted = 1'b1;
            if (m_in_flight) begin
                m_in_flight = 1'b0;
                m_stale     = !obs_rv;
            end else if (m_stale && obs_rv) begin
                m_stale = 1'b0;
            end
        end else begin
            npop = (!freeze1 && !freeze2) ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
            repeat (npop) void'(mq.pop_front());
            if (!m_booted) begin
                m_booted = 1'b1;
            end else if (exp_req) begin
                m_pc        = m_pc + 32'd4;
                m_in_flight = 1'b1;
            end else if (m_in_flight && obs_rv) begin
                mq.push_back(rd);
                m_in_flight = 1'b0;
            end else if (m_stale && obs_rv) begin
                m_stale = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        flush   = 1'b0;
        n_rst   = 1'b0;
        pend.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        flush    = 1'b0;
        flush_pc = 32'h0;
        freeze1  = 1'b1;
        freeze2  = 1'b1;
        n_rst    = 1'b1;
        #1;
        n_rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (imem.imem_req !== 1'b0)
            $display("FAIL reset_req: got %b want 0", imem.imem_req);
        if (imem.imem_req !== 1'b0) n_fail++;
        n_checks++;
        if (imem.imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want %h", imem.imem_addr, RESET_PC);
        end
        n_checks++;
        if (instruction0 !== 32'h0 || instruction1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pair: got %h/%h want 0/0", instruction0, instruction1);
        end
        n_checks++;
        if (nothing_filled !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_nf: got %b want 1", nothing_filled);
        end
        n_rst = 1'b1;
        cycle();
        n_checks++;
        if (obs_req !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_req: got %b want 0", obs_req);
        end
        cycle();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: got %b@%h want 1@%h", obs_req, obs_addr, RESET_PC);
        end
    endtask

    task automatic test_stream_fill();
        int unsigned n_req = 0;
        apply_reset();
        freeze1 = 1'b1;
        freeze2 = 1'b1;
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 24; i++) begin
            cycle();
            n_checks++;
            if (obs_req !== exp_req) begin
                n_fail++;
                $display("FAIL fill_req c%0d: got %b want %b", i, obs_req, exp_req);
            end
            if (obs_req === 1'b1) begin
                n_checks++;
                if (obs_addr !== 32'(4 * n_req)) begin
                    n_fail++;
                    $display("FAIL fill_addr: got %h want %h", obs_addr, 32'(4 * n_req));
                end
                n_req++;
            end
        end
        n_checks++;
        if (n_req != 8) begin
            n_fail++;
            $display("FAIL fill_req_count: got %0d want 8", n_req);
        end
        n_checks++;
        if (obs_req !== 1'b0 || obs_nf !== 1'b0 || obs_i0 !== 32'h100 || obs_i1 !== 32'h104)
        begin
            n_fail++;
            $display("FAIL fill_full: got req=%b nf=%b %h/%h want 0 0 100/104",
                     obs_req, obs_nf, obs_i0, obs_i1);
        end
    endtask

    task automatic test_pair_drain();
        logic [31:0] next_word = 32'h100;
        freeze1 = 1'b0;
        freeze2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_checks++;
            if (obs_i0 !== exp_i0 || obs_i1 !== exp_i1 || obs_nf !== exp_nf) begin
                n_fail++;
                $display("FAIL drain_pair c%0d: got %h/%h nf=%b want %h/%h nf=%b",
                         i, obs_i0, obs_i1, obs_nf, exp_i0, exp_i1, exp_nf);
            end
            n_checks++;
            if (obs_req !== exp_req || (obs_req && obs_addr !== exp_addr)) begin
                n_fail++;
                $display("FAIL drain_fetch c%0d: got %b@%h want %b@%h",
                         i, obs_req, obs_addr, exp_req, exp_addr);
            end
            // Consumed words must form the unbroken sequence 0x100, 0x104, ...
            if (obs_nf === 1'b0) begin
                n_checks++;
                if (obs_i0 !== next_word) begin
                    n_fail++;
                    $display("FAIL drain_order: got %h want %h", obs_i0, next_word);
                end
                next_word = next_word + 32'd4;
                if (obs_i1 !== 32'h0) begin
                    n_checks++;
                    if (obs_i1 !== next_word) begin
                        n_fail++;
                        $display("FAIL drain_order1: got %h want %h", obs_i1, next_word);
                    end
                    next_word = next_word + 32'd4;
                end
            end
        end
    endtask

    task automatic test_odd_count();
        bit found = 1'b0;
        apply_reset();
        freeze1 = 1'b0;
        freeze2 = 1'b0;
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (obs_nf === 1'b0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL odd_timeout: got nf=1 for 10 cycles want a word");
        end else begin
            n_checks++;
            if (obs_i0 !== 32'h100 || obs_i1 !== 32'h0) begin
                n_fail++;
                $display("FAIL odd_pair: got %h/%h want 100/0", obs_i0, obs_i1);
            end
            cycle();
            n_checks++;
            if (obs_nf !== 1'b1) begin
                n_fail++;
                $display("FAIL odd_empty: got nf=%b want 1", obs_nf);
            end
        end
    endtask

    task automatic test_push_pop_at_seven();
        bit found = 1'b0;
        apply_reset();
        freeze1 = 1'b1;
        freeze2 = 1'b1;
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (mq.size() == 7 && m_in_flight) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL seven_timeout: got no count=7 wait want one within 30 cycles");
        end else begin
            freeze1 = 1'b0;
            freeze2 = 1'b0;
            cycle();
            n_checks++;
            if (obs_rv !== 1'b1 || obs_i0 !== 32'h100 || obs_i1 !== 32'h104) begin
                n_fail++;
                $display("FAIL seven_pushpop: got rv=%b %h/%h want 1 100/104",
                         obs_rv, obs_i0, obs_i1);
            end
            freeze1 = 1'b1;
            cycle();
            n_checks++;
            if (obs_i0 !== 32'h108 || obs_i1 !== 32'h10c || obs_nf !== 1'b0) begin
                n_fail++;
                $display("FAIL seven_after: got %h/%h nf=%b want 108/10c 0",
                         obs_i0, obs_i1, obs_nf);
            end
            freeze1 = 1'b0;
            for (int i = 0; i < 10; i++) begin
                cycle();
                n_checks++;
                if (obs_i0 !== exp_i0 || obs_i1 !== exp_i1 || obs_nf !== exp_nf) begin
                    n_fail++;
                    $display("FAIL seven_drain c%0d: got %h/%h nf=%b want %h/%h nf=%b",
                             i, obs_i0, obs_i1, obs_nf, exp_i0, exp_i1, exp_nf);
                end
            end
        end
    endtask

    task automatic test_flush_wait();
        bit found = 1'b0;
        apply_reset();
        freeze1 = 1'b1;
        freeze2 = 1'b1;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (mq.size() >= 2 && m_in_flight) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL flush_setup: got no wait with 2 words want one within 40 cycles");
        end else begin
            flush    = 1'b1;
            flush_pc = 32'h400;
            cycle();
            n_checks++;
            if (obs_req !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_req: got %b want 0", obs_req);
            end
            flush = 1'b0;
            cycle();
            n_checks++;
            if (obs_nf !== 1'b1 || obs_req !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_empty: got nf=%b req=%b want 1 0", obs_nf, obs_req);
            end
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                cycle();
                n_checks++;
                if (obs_req !== exp_req) begin
                    n_fail++;
                    $display("FAIL flush_discard c%0d: got req=%b want %b", i, obs_req, exp_req);
                end
                if (obs_req === 1'b1) found = 1'b1;
            end
            n_checks++;
            if (!found || obs_addr !== 32'h400) begin
                n_fail++;
                $display("FAIL flush_target: got req=%b@%h want 1@400", found, obs_addr);
            end
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                cycle();
                if (obs_nf === 1'b0) found = 1'b1;
            end
            n_checks++;
            if (!found || obs_i0 !== 32'h500) begin
                n_fail++;
                $display("FAIL flush_first_word: got nf=%b %h want 0 500", obs_nf, obs_i0);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit found = 1'b0;
        apply_reset();
        freeze1 = 1'b1;
        freeze2 = 1'b1;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (mq.size() >= 1 && m_in_flight) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstwait_setup: got no second request want one within 20 cycles");
        end else begin
            // Assert reset while the request for 0x4 is outstanding; its response comes later.
            n_rst = 1'b0;
            #2;
            n_checks++;
            if (imem.imem_req !== 1'b0 || imem.imem_addr !== RESET_PC || nothing_filled !== 1'b1)
            begin
                n_fail++;
                $display("FAIL rstwait_async: got req=%b addr=%h nf=%b want 0 %h 1",
                         imem.imem_req, imem.imem_addr, nothing_filled, RESET_PC);
            end
            model_reset();
            @(posedge clk);
            #1;
            n_rst = 1'b1;
            cycle();
            n_checks++;
            if (obs_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rstwait_boot: got req=%b want 0", obs_req);
            end
            cycle();
            n_checks++;
            if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
                n_fail++;
                $display("FAIL rstwait_req: got %b@%h want 1@%h", obs_req, obs_addr, RESET_PC);
            end
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                cycle();
                if (obs_nf === 1'b0) found = 1'b1;
            end
            n_checks++;
            if (!found || obs_i0 !== 32'h100) begin
                n_fail++;
                $display("FAIL rstwait_word: got nf=%b %h want 0 100", obs_nf, obs_i0);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            freeze1  = ($urandom_range(3, 0) == 0);
            freeze2  = ($urandom_range(3, 0) == 0);
            flush    = ($urandom_range(15, 0) == 0);
            flush_pc = $urandom & 32'h0000_fffc;
            cycle();
            n_checks++;
            if (obs_req !== exp_req || obs_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rand_fetch c%0d: got %b@%h want %b@%h",
                         i, obs_req, obs_addr, exp_req, exp_addr);
            end
            n_checks++;
            if (obs_i0 !== exp_i0 || obs_i1 !== exp_i1 || obs_nf !== exp_nf) begin
                n_fail++;
                $display("FAIL rand_pair c%0d: got %h/%h nf=%b want %h/%h nf=%b",
                         i, obs_i0, obs_i1, obs_nf, exp_i0, exp_i1, exp_nf);
            end
        end
        flush   = 1'b0;
        freeze1 = 1'b1;
        freeze2 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream_fill();
        test_pair_drain();
        test_odd_count();
        test_push_pop_at_seven();
        test_flush_wait();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_pair_queue.md
# fetch_pair_queue

Instruction fetch queue that feeds the dual-issue scheduling assistant. It fetches 32-bit words sequentially from instruction memory and buffers them in a circular queue. It presents the two oldest words as the `instruction0`/`instruction1` pair and drives `nothing_filled`. The consumer's `freeze1`/`freeze2` outputs control when the pair advances. Sits between instruction memory and the scheduler; also accepts a branch redirect (flush).

## Interface
- `DEPTH`, default 8: queue entries; power of two, ≥4.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  fetch request. Memory accepts it in the same cycle; there is no ready signal.
- `imem_addr`  out  32  fetch address; equals the internal pc.
- `imem_rvalid`  in  1  response valid; arrives ≥1 cycle after the request.
- `imem_rdata`  in  32  response word.
- `flush`  in  1  redirect: empty the queue and restart fetch at `flush_pc`.
- `flush_pc`  in  32  redirect target; word aligned.
- `freeze1`, `freeze2`  in  1 each  scheduler freezes; the pair advances only when both are low.
- `instruction0`  out  32  oldest queued word, or 0 if the queue is empty.
- `instruction1`  out  32  second-oldest word, or 0 if count<2.
- `nothing_filled`  out  1  high when count==0.

## Operation
- Storage: `DEPTH` words plus read pointer, write pointer and count, each clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- Fetch FSM has four states: BOOT, IDLE, WAIT, DISCARD. At most one request is outstanding.
  - BOOT (reset state): `imem_req`=0. Moves to IDLE on the next edge.
  - IDLE: `imem_req`=1 when count<DEPTH and flush=0.
    - When the request is issued: pc += 4, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT: `imem_req`=0.
    - If flush=1: go to DISCARD, or to IDLE if `imem_rvalid` is also high this cycle; the word is dropped either way.
    - Else if `imem_rvalid`=1: push `imem_rdata`, go to IDLE.
  - DISCARD: `imem_req`=0. On `imem_rvalid`, drop the word and go to IDLE. A further flush here only updates pc.
  - `imem_rvalid` in BOOT or IDLE is ignored.
- Space check: a request is issued only when count<DEPTH, so a push never overflows. Pops in the response cycle only increase space.
- Pop rule: when freeze1=0, freeze2=0 and flush=0, pop min(count,2) entries.
  - count==1: pop 1 entry; `instruction1` reads 0, which the scheduler treats as an empty lane.
  - count==0: pop nothing.
- Count update on each edge: count_next = count + push − pop. Push and pop in the same cycle are legal, including when count==DEPTH−1 and when a pointer wraps.
- A fetched word equal to 0 is queued unchanged; the queue does not interpret it.
- Flush has priority over push and pop. On the edge where flush is sampled high:
  - count, rd_ptr and wr_ptr are set to 0.
  - pc is set to `flush_pc`.
  - No request is issued in that cycle.
- Output muxing is combinational from the queue state:
  - `instruction0` = mem[rd_ptr] when count≥1.
  - `instruction1` = mem[rd_ptr+1 mod DEPTH] when count≥2.
  - `nothing_filled` = (count==0).

## Timing
- Reset values (asynchronous): state=BOOT, pc=`RESET_PC`, count=0, pointers=0. Therefore `imem_req`=0, `imem_addr`=`RESET_PC`, `instruction0`=`instruction1`=0, `nothing_filled`=1.
- First request is issued in the first cycle after BOOT.
- Request-to-visible latency:
  - Request in cycle t.
  - Earliest response in t+1, pushed on the edge ending t+1.
  - Word appears at `instruction0` in t+2.
  - Next request is issued in t+2, so peak fill rate is 1 word per 2 cycles with zero-wait memory.
- Pop latency: the scheduler latches the pair on the same edge that pops it. The next pair is visible in the following cycle.
- Freeze is level sensitive: while either freeze is high, the outputs hold and fetch continues until the queue is full.
- Flush: the queue is empty and `nothing_filled`=1 in the cycle after the flush. The first request to `flush_pc` is issued:
  - one cycle after the flush, if the FSM is not in DISCARD;
  - otherwise in the cycle after the stale response has been dropped.
- Reset asserted mid-operation: all state returns to reset values immediately; any outstanding response is then ignored (IDLE/BOOT).

## Test plan
- Reset then stream: memory returns word = addr+0x100 with 1-cycle latency; freezes held high. Expect addresses 0,4,8,…,28 to be requested. After 8 words, `imem_req` stays 0, count=8, `instruction0`=0x100, `instruction1`=0x104.
- Pair drain: from the full queue, hold freezes low. Expect pairs (0x100,0x104), (0x108,0x10C), … on successive cycles. Fetch resumes and pointers wrap past entry 7 without loss or duplication.
- Odd count: queue holds only 0x100 and freezes are low. Expect `instruction1`=0, one pop, then `nothing_filled`=1 on the next cycle.
- Simultaneous push and pop at count=7: a response arrives while a pair is popped. Expect count=6 on the next cycle and correct word order.
- Flush during WAIT with a 3-cycle memory latency, `flush_pc`=0x400. Expect the stale word to be dropped, DISCARD to be exited, the next request at 0x400, and the first visible word to be 0x400+0x100.
- Reset asserted mid-WAIT with the response arriving after release. Expect the response to be ignored, BOOT for one cycle, then a request at `RESET_PC`.
